// File: rtl/apb_node_pkg.sv
// apb_node_pkg: shared types and sizing helpers for the APB node with watchdog
package apb_node_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DECERR} state_e;
   localparam int ERR_CNT_W = 16;
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: inclusive-range address decode, lowest index wins on overlap
module apb_addr_decoder
   import apb_node_pkg::*;
#(
   parameter int NB_SLAVES = 10,
   parameter int ADDR_W    = 32,
   parameter int IDX_W     = idx_width(NB_SLAVES)
) (
   input  logic [ADDR_W-1:0]           addr_i,
   input  logic [NB_SLAVES*ADDR_W-1:0] start_addr_i,
   input  logic [NB_SLAVES*ADDR_W-1:0] end_addr_i,
   output logic [NB_SLAVES-1:0]        match_o,
   output logic [IDX_W-1:0]            idx_o,
   output logic                        hit_o
);
   // scanning downwards lets the lowest matching index overwrite the rest
   always_comb begin
      match_o = '0;
      idx_o   = '0;
      hit_o   = 1'b0;
      for (int k = NB_SLAVES - 1; k >= 0; k--) begin
         if (addr_i >= start_addr_i[k*ADDR_W +: ADDR_W] && addr_i <= end_addr_i[k*ADDR_W +: ADDR_W]) begin
            hit_o      = 1'b1;
            idx_o      = IDX_W'(k);
            match_o    = '0;
            match_o[k] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/apb_node_wd.sv
// apb_node_wd: APB 1-to-N node with decode-error response and wait-state watchdog
module apb_node_wd
   import apb_node_pkg::*;
#(
   parameter int NB_SLAVES      = 10,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [APB_ADDR_WIDTH-1:0]           paddr_i,
   input  logic [APB_DATA_WIDTH-1:0]           pwdata_i,
   input  logic                                pwrite_i,
   input  logic                                psel_i,
   input  logic                                penable_i,
   output logic [APB_DATA_WIDTH-1:0]           prdata_o,
   output logic                                pready_o,
   output logic                                pslverr_o,
   input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] start_addr_i,
   input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] end_addr_i,
   output logic [APB_ADDR_WIDTH-1:0]           m_paddr_o,
   output logic [APB_DATA_WIDTH-1:0]           m_pwdata_o,
   output logic                                m_pwrite_o,
   output logic [NB_SLAVES-1:0]                m_psel_o,
   output logic [NB_SLAVES-1:0]                m_penable_o,
   input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0] m_prdata_i,
   input  logic [NB_SLAVES-1:0]                m_pready_i,
   input  logic [NB_SLAVES-1:0]                m_pslverr_i,
   output logic [ERR_CNT_W-1:0]                decerr_cnt_o,
   output logic [ERR_CNT_W-1:0]                tout_cnt_o
);
   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
   localparam int IDX_W = idx_width(NB_SLAVES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
   localparam logic TOUT_EN = (TIMEOUT_CYCLES != 0);
   state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d, dec_idx;
   logic [ERR_CNT_W-1:0] decerr_q, decerr_d, tout_q, tout_d;
   logic [NB_SLAVES-1:0] dec_oh;
   logic dec_hit, setup, in_acc, slv_rdy, done, tout, dec_done;

   apb_addr_decoder #(.NB_SLAVES(NB_SLAVES), .ADDR_W(APB_ADDR_WIDTH), .IDX_W(IDX_W)) u_dec (
      .addr_i(paddr_i), .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
      .match_o(dec_oh), .idx_o(dec_idx), .hit_o(dec_hit)
   );

   assign m_paddr_o    = paddr_i;
   assign m_pwdata_o   = pwdata_i;
   assign m_pwrite_o   = pwrite_i;
   assign decerr_cnt_o = decerr_q;
   assign tout_cnt_o   = tout_q;
   // setup is masked by reset so no select leaks out while rst_i is high
   assign setup    = psel_i & ~penable_i & ~rst_i;
   assign in_acc   = (state_q == ACCESS) & psel_i;
   assign slv_rdy  = m_pready_i[idx_q];
   assign done     = in_acc & penable_i & slv_rdy;
   assign tout     = in_acc & TOUT_EN & (cnt_q == CNT_MAX) & ~done;
   assign dec_done = (state_q == DECERR) & psel_i & penable_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         decerr_q <= '0;
         tout_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         decerr_q <= decerr_d;
         tout_q   <= tout_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      decerr_d = decerr_q;
      tout_d   = tout_q;
      case (state_q)
         IDLE: if (setup) begin
            state_d = dec_hit ? ACCESS : DECERR;
            idx_d   = dec_idx;
            cnt_d   = '0;
         end
         ACCESS: begin
            if (!psel_i || done || tout) state_d = IDLE;
            if (tout) tout_d = (tout_q == '1) ? tout_q : tout_q + 1'b1;
            else if (in_acc && !slv_rdy && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
         end
         DECERR: if (!psel_i || penable_i) begin
            state_d = IDLE;
            if (dec_done) decerr_d = (decerr_q == '1) ? decerr_q : decerr_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_psel_o    = '0;
      m_penable_o = '0;
      pready_o    = 1'b0;
      pslverr_o   = 1'b0;
      prdata_o    = '0;
      if (state_q == IDLE && setup) m_psel_o = dec_oh;
      if (in_acc && !tout) begin
         m_psel_o[idx_q]    = 1'b1;
         m_penable_o[idx_q] = penable_i;
         pready_o           = slv_rdy;
         pslverr_o          = m_pslverr_i[idx_q];
         prdata_o           = m_prdata_i[idx_q*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      end
      if (tout || dec_done) begin
         pready_o  = 1'b1;
         pslverr_o = 1'b1;
      end
   end
endmodule

// File: tb/tb_apb_node_wd.sv
// tb_apb_node_wd: randomized APB traffic against a region-map reference model with a queue scoreboard
module tb_apb_node_wd;
   localparam int NB = 10;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int T  = 4;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic [AW-1:0] paddr_i = '0;
   logic [DW-1:0] pwdata_i = '0;
   logic pwrite_i = 1'b0, psel_i = 1'b0, penable_i = 1'b0;
   logic [DW-1:0] prdata_o;
   logic pready_o, pslverr_o;
   logic [NB*AW-1:0] start_addr_i, end_addr_i;
   logic [AW-1:0] m_paddr_o;
   logic [DW-1:0] m_pwdata_o;
   logic m_pwrite_o;
   logic [NB-1:0] m_psel_o, m_penable_o;
   logic [NB*DW-1:0] m_prdata_i;
   logic [NB-1:0] m_pready_i = '0, m_pslverr_i = '0;
   logic [15:0] decerr_cnt_o, tout_cnt_o;

   logic [AW-1:0] st [NB];
   logic [AW-1:0] en [NB];
   logic [DW-1:0] rd_v [NB];

   always #5 clk_i = ~clk_i;

   always_comb begin
      for (int j = 0; j < NB; j++) begin
         start_addr_i[j*AW +: AW] = st[j];
         end_addr_i[j*AW +: AW]   = en[j];
         m_prdata_i[j*DW +: DW]   = rd_v[j];
      end
   end

   apb_node_wd #(.NB_SLAVES(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pwrite_i(pwrite_i),
      .psel_i(psel_i), .penable_i(penable_i), .prdata_o(prdata_o), .pready_o(pready_o),
      .pslverr_o(pslverr_o), .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
      .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o), .m_pwrite_o(m_pwrite_o),
      .m_psel_o(m_psel_o), .m_penable_o(m_penable_o), .m_prdata_i(m_prdata_i),
      .m_pready_i(m_pready_i), .m_pslverr_i(m_pslverr_i),
      .decerr_cnt_o(decerr_cnt_o), .tout_cnt_o(tout_cnt_o)
   );

   typedef struct {
      logic [NB-1:0] soh;
      logic [NB-1:0] aoh;
      int            cyc;
      logic          err;
      logic [DW-1:0] rdata;
      logic [15:0]   dc;
      logic [15:0]   tc;
   } exp_t;

   exp_t sb[$];
   exp_t me;
   int checks = 0;
   int fails = 0;
   int acc_n = 0;
   logic [15:0] m_dc = '0, m_tc = '0, pdc, ptc;
   logic pend = 1'b0;
   logic [AW-1:0] a;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic int decode(input logic [AW-1:0] ad);
      for (int k = 0; k < NB; k++)
         if (ad >= st[k] && ad <= en[k]) return k;
      return -1;
   endfunction

   // one upstream transfer; the addressed slave answers after `waits` wait states
   task automatic xfer(input logic [AW-1:0] ad, input logic w, input int waits, input logic [DW-1:0] rd, input logic se);
      exp_t e;
      int k, n;
      logic dn;
      k = decode(ad);
      e.soh = '0;
      if (k >= 0) e.soh[k] = 1'b1;
      if (k < 0) begin
         e.aoh = '0; e.cyc = 1; e.err = 1'b1; e.rdata = '0;
         if (m_dc != 16'hFFFF) m_dc++;
      end else if (waits > T) begin
         e.aoh = '0; e.cyc = T + 1; e.err = 1'b1; e.rdata = '0;
         if (m_tc != 16'hFFFF) m_tc++;
      end else begin
         e.aoh = e.soh; e.cyc = waits + 1; e.err = se; e.rdata = rd;
      end
      e.dc = m_dc;
      e.tc = m_tc;
      sb.push_back(e);
      for (int j = 0; j < NB; j++) begin
         rd_v[j] = (j == k) ? rd : $urandom;
         m_pslverr_i[j] = (j == k) ? se : 1'($urandom);
      end
      paddr_i = ad; pwrite_i = w; pwdata_i = $urandom;
      psel_i = 1'b1; penable_i = 1'b0; m_pready_i = '0;
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      n = 1;
      m_pready_i = (n > waits) ? '1 : '0;
      dn = 1'b0;
      while (!dn) begin
         @(negedge clk_i);
         dn = pready_o;
         @(posedge clk_i); #1;
         if (!dn) begin
            n++;
            if (n > 20) begin
               fails++;
               $display("FAIL xfer_budget: actual no pready after %0d cycles required completion", n);
               $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
               $fatal(1);
            end
            m_pready_i = (n > waits) ? '1 : '0;
         end
      end
      psel_i = 1'b0; penable_i = 1'b0; m_pready_i = '0;
   endtask

   initial forever begin
      @(negedge clk_i);
      if (!rst_i) begin
         if (pend) begin
            chk("decerr_cnt", 64'(decerr_cnt_o), 64'(pdc));
            chk("tout_cnt", 64'(tout_cnt_o), 64'(ptc));
            pend = 1'b0;
         end
         if (psel_i && !penable_i) begin
            acc_n = 0;
            if (sb.size() > 0) chk("setup_psel", 64'(m_psel_o), 64'(sb[0].soh));
         end
         if (psel_i && penable_i) acc_n++;
         if (pready_o) begin
            if (sb.size() == 0) begin
               checks++; fails++;
               $display("FAIL unexpected_pready: actual 1 required 0");
            end else begin
               me = sb.pop_front();
               chk("prdata", 64'(prdata_o), 64'(me.rdata));
               chk("pslverr", 64'(pslverr_o), 64'(me.err));
               chk("access_cycles", 64'(acc_n), 64'(me.cyc));
               chk("access_psel", 64'(m_psel_o), 64'(me.aoh));
               pdc = me.dc;
               ptc = me.tc;
               pend = 1'b1;
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < NB; k++) begin
         st[k] = 32'h1A10_0000 + k * 32'h1000;
         en[k] = st[k] + 32'hFFF;
         rd_v[k] = '0;
      end
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_outputs", {m_psel_o, m_penable_o, pready_o, pslverr_o, prdata_o}, 64'd0);
      chk("reset_counters", {decerr_cnt_o, tout_cnt_o}, 64'd0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      xfer(32'h1A10_2004, 1'b0, 2, 32'hCAFE_0001, 1'b0);
      xfer(32'h1A13_0000, 1'b1, 0, 32'h1234_5678, 1'b0);
      xfer(32'h1A10_0010, 1'b0, 255, 32'h0BAD_F00D, 1'b0);
      xfer(32'h1A10_0100, 1'b0, 0, 32'h0000_00A0, 1'b0);
      xfer(32'h1A10_5000, 1'b1, 0, 32'h0000_00A5, 1'b1);
      xfer(32'h1A10_7ABC, 1'b0, T, 32'h0000_7777, 1'b0);
      xfer(en[3], 1'b0, 1, 32'h0000_3333, 1'b0);
      xfer(st[4], 1'b0, 1, 32'h0000_4444, 1'b0);
      xfer(en[NB-1] + 1, 1'b0, 0, 32'h0, 1'b0);
      for (int i = 0; i < 200; i++) begin
         a = 32'h1A10_0000 + $urandom_range(0, 32'hBFFF);
         if ($urandom_range(0, 9) == 0) a = 32'h1A13_0000 + $urandom_range(0, 255);
         xfer(a, 1'($urandom), $urandom_range(0, 6), $urandom, 1'($urandom));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk_i); #1;
         end
      end
      // abandoned transfer: psel drops mid-access
      paddr_i = 32'h1A10_1008; psel_i = 1'b1; penable_i = 1'b0; m_pready_i = '0;
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      @(posedge clk_i); #1;
      psel_i = 1'b0; penable_i = 1'b0;
      #1;
      chk("abort_outputs", {m_psel_o, m_penable_o, pready_o, pslverr_o}, 64'd0);
      @(posedge clk_i); #1;
      chk("abort_counters", {decerr_cnt_o, tout_cnt_o}, {m_dc, m_tc});
      st[3] = 32'h1A10_1000;
      @(posedge clk_i); #1;
      xfer(32'h1A10_1000, 1'b0, 0, 32'h0000_1111, 1'b0);
      xfer(32'h1A10_2800, 1'b0, 1, 32'h0000_2222, 1'b0);
      xfer(32'h1A10_3000, 1'b0, 0, 32'h0000_3030, 1'b0);
      // asynchronous reset in the middle of a stalled access
      paddr_i = 32'h1A10_5004; psel_i = 1'b1; penable_i = 1'b0; m_pready_i = '0;
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      @(negedge clk_i); #2;
      rst_i = 1'b1;
      #1;
      chk("midreset_outputs", {m_psel_o, m_penable_o, pready_o, pslverr_o, prdata_o}, 64'd0);
      chk("midreset_counters", {decerr_cnt_o, tout_cnt_o}, 64'd0);
      m_dc = '0;
      m_tc = '0;
      pend = 1'b0;
      #1;
      psel_i = 1'b0; penable_i = 1'b0;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      xfer(32'h1A10_6000, 1'b0, 1, 32'h0000_6666, 1'b0);
      xfer(32'h1A13_0000, 1'b0, 0, 32'h0, 1'b0);
      repeat (3) @(posedge clk_i);
      #1;
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/apb_node_wd.md
APB_NODE_WD -- requirements
Module: apb_node_wd

Interface
REQ-001 Parameter NB_SLAVES, default 10: number of downstream APB slave ports, legal range 1..16.
REQ-002 Parameter APB_ADDR_WIDTH, default 32: address width.
REQ-003 Parameter APB_DATA_WIDTH, default 32: data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 256: maximum wait-state count before abort; 0 disables the timeout.
REQ-005 Ports shall be:
- clk_i  in  1  sole clock; rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- paddr_i  in  APB_ADDR_WIDTH  upstream address.
- pwdata_i  in  APB_DATA_WIDTH  upstream write data.
- pwrite_i, psel_i, penable_i  in  1 each  upstream controls.
- prdata_o  out  APB_DATA_WIDTH  upstream read data.
- pready_o, pslverr_o  out  1 each  upstream response.
- start_addr_i, end_addr_i  in  NB_SLAVES*APB_ADDR_WIDTH  inclusive region bounds per slave.
- m_paddr_o, m_pwdata_o, m_pwrite_o  out  shared  broadcast to all slaves.
- m_psel_o, m_penable_o  out  NB_SLAVES  per-slave select/enable.
- m_prdata_i  in  NB_SLAVES*APB_DATA_WIDTH  per-slave read data.
- m_pready_i, m_pslverr_i  in  NB_SLAVES  per-slave response.
- decerr_cnt_o, tout_cnt_o  out  16  saturating error counters.

Function
REQ-006 Decode: slave k matches when start_k <= paddr_i <= end_k (unsigned); on overlap, lowest index wins; no match = decode error.
REQ-007 FSM states IDLE, ACCESS, DECERR; reset state IDLE.
REQ-008 IDLE with psel_i=1, penable_i=0 (setup): matched index latched; m_psel_o[idx]=1 in the same cycle; counter cleared; next state ACCESS; if no match, no m_psel_o bit asserted; next state DECERR.
REQ-009 ACCESS: m_psel_o[idx] and m_penable_o[idx] = psel_i, penable_i; pready_o, pslverr_o, prdata_o come from the latched slave; paddr_i changes ignored for slave selection.
REQ-010 ACCESS wait counter: increments once per cycle with m_pready_i[idx]=0, saturating at TIMEOUT_CYCLES.
REQ-011 When counter == TIMEOUT_CYCLES (nonzero): pready_o=1, pslverr_o=1, prdata_o=0, m_psel_o and m_penable_o all 0 in that cycle; tout_cnt_o increments; next state IDLE.
REQ-012 DECERR access cycle (penable_i=1): pready_o=1, pslverr_o=1, prdata_o=0, zero wait states; decerr_cnt_o increments; next state IDLE.
REQ-013 Completion (pready_o=1 in ACCESS) returns to IDLE; an immediate back-to-back setup in the next cycle is accepted with no bubble.
REQ-014 psel_i dropping to 0 in ACCESS/DECERR: all m_psel_o, m_penable_o deasserted that cycle; next state IDLE; no counter update.
REQ-015 m_paddr_o, m_pwdata_o, m_pwrite_o shall be combinational copies of upstream signals.
REQ-016 Outside ACCESS/DECERR: pready_o=0, pslverr_o=0, prdata_o=0.
REQ-017 Error counters saturate at 16'hFFFF; a timeout and a slave pready arriving in the same cycle resolve as normal completion.

Reset
REQ-018 rst_i=1 asynchronously forces: state IDLE, wait counter 0, latched index 0, decerr_cnt_o=0, tout_cnt_o=0, all m_psel_o/m_penable_o=0, pready_o=0, pslverr_o=0, prdata_o=0; an in-flight transfer is dropped without response.

Structure
REQ-019 Package apb_node_pkg shall hold the FSM state enum, the counter width (clog2 of TIMEOUT_CYCLES+1, minimum 1), and the 16-bit error counter width constant.
REQ-020 Sub-module apb_addr_decoder (combinational: address + region arrays -> one-hot match, index, hit flag) shall implement REQ-006.

Verification
REQ-021 Read 0x1A10_2004 with regions as in PULPino map, slave 2 ready after 2 waits, prdata=0xCAFE_0001 -> m_psel_o=0x004; pready_o on 3rd access cycle; prdata_o=0xCAFE_0001, pslverr_o=0.
REQ-022 Write 0x1A13_0000 (unmapped) -> m_psel_o=0 throughout; pready_o=1, pslverr_o=1 in first access cycle; decerr_cnt_o=1.
REQ-023 TIMEOUT_CYCLES=4, slave 0 never ready -> pslverr_o=1 in access cycle 5; m_psel_o[0]=0 that cycle; tout_cnt_o=1.
REQ-024 Overlapping regions 1 and 3 both cover 0x1A10_1000 -> only m_psel_o[1] asserted.
REQ-025 rst_i pulsed mid-ACCESS (asynchronous to clock) -> all outputs 0 immediately; next setup decodes normally.
REQ-026 Two back-to-back zero-wait transfers to slaves 0 then 5 -> second setup accepted in the cycle after completion; m_psel_o sequence 0x001, 0x001, 0x020, 0x020.
